// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score/match logic.
package pong_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t PLAY    = 2'd1;
    localparam state_t LOCKOUT = 2'd2;
    localparam state_t OVER    = 2'd3;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam logic [6:0] SCORE_MAX     = 7'd99;

    // Post-increment score value, pinned at SCORE_MAX like the BCD counter.
    function automatic logic [6:0] sat_inc(input logic [6:0] v);
        return (v >= SCORE_MAX) ? SCORE_MAX : v + 7'd1;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter, saturating at 99, with a parallel binary copy.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output bcd_digit_t ones,
    output bcd_digit_t tens,
    output logic [6:0] bin
);

    bcd_digit_t ones_q, tens_q;
    logic [6:0] bin_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_q <= '0;
            tens_q <= '0;
            bin_q  <= '0;
        end else if (clr) begin
            ones_q <= '0;
            tens_q <= '0;
            bin_q  <= '0;
        end else if (inc && (bin_q != SCORE_MAX)) begin
            bin_q <= bin_q + 7'd1;
            if (ones_q == BCD_MAX_DIGIT) begin
                ones_q <= '0;
                tens_q <= tens_q + 4'd1;
            end else begin
                ones_q <= ones_q + 4'd1;
            end
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;
    assign bin  = bin_q;

endmodule

// File: rtl/score_keeper.sv
// Pong match FSM and per-player BCD scores; all outputs registered.
// Define WIN_BY_TWO_EN to require a two-point winning margin (99 always wins).
module score_keeper
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE      = 7,
    parameter int unsigned LOCKOUT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       score1,
    input  logic       score2,
    input  logic       serve,
    output bcd_digit_t p1_ones,
    output bcd_digit_t p1_tens,
    output bcd_digit_t p2_ones,
    output bcd_digit_t p2_tens,
    output logic       playing,
    output logic       round_start,
    output logic       game_over,
    output logic       winner
);

    localparam logic [6:0] WIN_BIN   = 7'(WIN_SCORE);
    localparam logic [7:0] LOCK_INIT = 8'(LOCKOUT_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] lock_q, lock_d;
    logic       score1_q, score2_q;
    logic       winner_q, winner_d;
    logic       game_over_q, playing_q, round_start_q;

    logic       edge1, edge2, inc1, inc2, clr, start;
    logic       p1_wins, p2_wins;
    logic [6:0] p1_bin, p2_bin, p1_next, p2_next;

    bcd_counter2 u_p1 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc1),
        .ones  (p1_ones),
        .tens  (p1_tens),
        .bin   (p1_bin)
    );

    bcd_counter2 u_p2 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .inc   (inc2),
        .ones  (p2_ones),
        .tens  (p2_tens),
        .bin   (p2_bin)
    );

    assign edge1   = score1 & ~score1_q;
    assign edge2   = score2 & ~score2_q;
    assign p1_next = sat_inc(p1_bin);
    assign p2_next = sat_inc(p2_bin);

`ifdef WIN_BY_TWO_EN
    assign p1_wins = (p1_next == SCORE_MAX) ||
                     ((p1_next >= WIN_BIN) && (p1_next >= p2_bin + 7'd2));
    assign p2_wins = (p2_next == SCORE_MAX) ||
                     ((p2_next >= WIN_BIN) && (p2_next >= p1_bin + 7'd2));
`else
    assign p1_wins = (p1_next == WIN_BIN);
    assign p2_wins = (p2_next == WIN_BIN);
`endif

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        winner_d = winner_q;
        inc1     = 1'b0;
        inc2     = 1'b0;
        clr      = 1'b0;
        start    = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (serve) begin
                    state_d = PLAY;
                    start   = 1'b1;
                end
            end
            PLAY: begin
                // A tied edge awards nothing but still forces the lockout.
                if (edge1 && edge2) begin
                    state_d = LOCKOUT;
                    lock_d  = LOCK_INIT;
                end else if (edge1) begin
                    inc1 = 1'b1;
                    if (p1_wins) begin
                        state_d  = OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = LOCKOUT;
                        lock_d  = LOCK_INIT;
                    end
                end else if (edge2) begin
                    inc2 = 1'b1;
                    if (p2_wins) begin
                        state_d  = OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = LOCKOUT;
                        lock_d  = LOCK_INIT;
                    end
                end
            end
            LOCKOUT: begin
                if (frame_tick) begin
                    if (lock_q <= 8'd1) begin
                        state_d = PLAY;
                        lock_d  = '0;
                        start   = 1'b1;
                    end else begin
                        lock_d = lock_q - 8'd1;
                    end
                end
            end
            OVER: begin
                if (serve) begin
                    clr      = 1'b1;
                    state_d  = PLAY;
                    start    = 1'b1;
                    winner_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lock_q        <= '0;
            score1_q      <= 1'b0;
            score2_q      <= 1'b0;
            winner_q      <= 1'b0;
            game_over_q   <= 1'b0;
            playing_q     <= 1'b0;
            round_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lock_q        <= lock_d;
            score1_q      <= score1;
            score2_q      <= score2;
            winner_q      <= winner_d;
            game_over_q   <= (state_d == OVER);
            playing_q     <= (state_d == PLAY);
            round_start_q <= start;
        end
    end

    assign playing     = playing_q;
    assign round_start = round_start_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly downstream of the ball stage and consumes its `score1`/`score2` point pulses.
- Keeps per-player two-digit BCD scores and runs the match state machine (idle, play, post-point lockout, game over).
- Emits a `round_start` pulse that tells the top level to re-serve the ball.
- Drives BCD digits and status flags to the VGA text/score overlay.

Parameters:
- WIN_SCORE, 7, points needed to win; legal 1..99.
- LOCKOUT_FRAMES, 60, frame ticks during which score inputs are ignored after a point; legal 1..255.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  asynchronous active-high reset (btnC)
- frame_tick  input  1  one-cycle pulse per frame, the same 60 Hz refresh tick used by the ball stage
- score1  input  1  point for player 1, from the ball stage
- score2  input  1  point for player 2, from the ball stage
- serve  input  1  one-cycle start/restart request (debounced button)
- p1_ones  output  4  player 1 score, BCD units digit
- p1_tens  output  4  player 1 score, BCD tens digit
- p2_ones  output  4  player 2 score, BCD units digit
- p2_tens  output  4  player 2 score, BCD tens digit
- playing  output  1  high only in PLAY
- round_start  output  1  one-cycle pulse when a rally begins
- game_over  output  1  high in OVER
- winner  output  1  0 = player 1, 1 = player 2; valid while game_over is high

Behaviour:
- Reset, asynchronous: state goes to IDLE; all digits 0; playing, round_start, game_over and winner all 0; lockout counter 0; edge registers 0.
- Point detection:
  - score1 and score2 are registered.
  - A point is a rising edge: input = 1 and registered input = 0.
  - Points count only in PLAY.
  - A level held high for many cycles counts exactly once.
- Simultaneous score1 and score2 edges in the same cycle: no point is awarded; the FSM enters LOCKOUT as for a normal point.
- IDLE:
  - Scores are held at 0.
  - serve → PLAY, with round_start = 1 for one cycle on that transition.
- PLAY, on a point edge:
  - The scorer's BCD counter increments; the new value is visible the next cycle (latency 1).
  - If the scorer's new score equals WIN_SCORE → OVER, winner is set to the scorer, and game_over rises in that same next cycle.
  - Otherwise → LOCKOUT, with the counter loaded to LOCKOUT_FRAMES.
  - serve is ignored in PLAY.
- LOCKOUT:
  - The counter decrements on each frame_tick.
  - When frame_tick arrives with counter = 1 → PLAY, with round_start pulsed for one cycle.
  - score inputs and serve are ignored.
- OVER:
  - Scores, winner and game_over are held.
  - serve clears all digits and goes → PLAY, with round_start pulsed; winner clears to 0 and game_over drops.
- BCD arithmetic:
  - Units digit 9 + 1 → 0, with tens digit +1.
  - The counter saturates at 99 and never wraps.
  - A parallel 7-bit binary copy per player is used for all comparisons.
- Reset mid-operation (any state, any lockout count) gives the exact reset values on the next observable cycle.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: WIN_BY_TWO_EN.
- Defined:
  - Game over requires scorer ≥ WIN_SCORE and scorer − opponent ≥ 2, evaluated on the post-increment values.
  - As a tie-break guard, reaching 99 ends the game for that player regardless of margin.
- Undefined: game over exactly when scorer = WIN_SCORE; the margin logic is absent.

Decomposition:
- Shared package pong_pkg contains:
  - the state type: IDLE, PLAY, LOCKOUT, OVER (2-bit);
  - the bcd_digit_t 4-bit type;
  - constants BCD_MAX_DIGIT = 9 and SCORE_MAX = 99.
- Sub-module bcd_counter2, instantiated once per player:
  - Inputs: clk, reset, clr, inc.
  - Outputs: ones, tens, bin[6:0].
  - Two-digit BCD count with saturation at 99.

Test Plan:
1. Reset, serve pulse → round_start high exactly one cycle; playing = 1; all digits 0.
2. In PLAY, score1 held high for 5 cycles → p1_ones = 1 after 1 cycle, not 5. Then LOCKOUT: further score1 pulses during 60 frame ticks are ignored. round_start fires on the 60th tick.
3. WIN_SCORE = 7: 6 player-2 points then one more → p2_ones = 7, game_over = 1, winner = 1, playing = 0. Next, serve → all digits 0, game_over = 0, round_start pulsed.
4. WIN_SCORE = 12: player 1 scores 10 points → p1_tens = 1, p1_ones = 0 (BCD carry). WIN_SCORE = 99, 99 points → tens and ones remain 9/9 and game over.
5. score1 and score2 edges in the same cycle → both scores unchanged; FSM in LOCKOUT. Assert reset halfway through the lockout → IDLE, all outputs 0.
6. With WIN_BY_TWO_EN defined and WIN_SCORE = 7: scores reach 6–6, then player 1 scores to 7–6 → no game over. Player 1 scores again to 8–6 → game_over = 1, winner = 0.
